// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types, opcode/funct constants and control-unit enums
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALUSrc: second ALU operand
    localparam logic [1:0] SRC_RT    = 2'd0;
    localparam logic [1:0] SRC_SEXT  = 2'd1;
    localparam logic [1:0] SRC_ZEXT  = 2'd2;
    localparam logic [1:0] SRC_SHAMT = 2'd3;

    // JumpSel: next-PC source when PCWEN fires outside FETCH
    localparam logic [1:0] JS_PC4    = 2'd0;
    localparam logic [1:0] JS_TARGET = 2'd1;
    localparam logic [1:0] JS_REG    = 2'd2;

    // RegDest: destination register field
    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WBACK, HALT
    } cu_state_t;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_JAL, CLS_HALT
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        logic         bne;
        aluop_t       aluop;
        logic [1:0]   alusrc;
        logic [1:0]   jumpsel;
        logic [1:0]   regdest;
        logic         memtoreg;
        logic         lui;
        logic         jal;
    } decode_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - cache handshake and datapath control bundle
interface multicycle_control_unit_if;
    import cpu_types_pkg::*;

    word_t      iload;
    logic       ihit;
    logic       dhit;
    logic       zero;
    logic       imemREN;
    logic       dREN;
    logic       dWEN;
    logic       IRWEN;
    logic       PCWEN;
    logic       RegWEN;
    logic       PCSrc;
    logic [1:0] JumpSel;
    logic [1:0] ALUSrc;
    logic [1:0] RegDest;
    logic       MemtoReg;
    logic       LUI;
    logic       JAL;
    aluop_t     aluop;
    regbits_t   rs;
    regbits_t   rt;
    regbits_t   rd;
    logic [15:0] imm;
    word_t      shamt;
    logic       halt;
    logic       memerr;

    modport master (
        input  iload, ihit, dhit, zero,
        output imemREN, dREN, dWEN, IRWEN, PCWEN, RegWEN, PCSrc,
               JumpSel, ALUSrc, RegDest, MemtoReg, LUI, JAL, aluop,
               rs, rt, rd, imm, shamt, halt, memerr
    );

    modport slave (
        output iload, ihit, dhit, zero,
        input  imemREN, dREN, dWEN, IRWEN, PCWEN, RegWEN, PCSrc,
               JumpSel, ALUSrc, RegDest, MemtoReg, LUI, JAL, aluop,
               rs, rt, rd, imm, shamt, halt, memerr
    );

endinterface

// File: rtl/multicycle_control_unit_decode.sv
// rtl/multicycle_control_unit_decode.sv - cu_decode: IR opcode/funct to instruction class and static selects
module cu_decode
    import cpu_types_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);

    // Pure table lookup; unrecognised encodings fall out as CLS_NOP
    always_comb begin
        dec       = '0;
        dec.cls   = CLS_NOP;
        dec.aluop = ALU_SLL;
        case (opcode)
            OP_RTYPE: begin
                dec.cls     = CLS_ALU;
                dec.regdest = RD_RD;
                case (funct)
                    FN_SLL:          begin dec.aluop = ALU_SLL; dec.alusrc = SRC_SHAMT; end
                    FN_SRL:          begin dec.aluop = ALU_SRL; dec.alusrc = SRC_SHAMT; end
                    FN_ADD, FN_ADDU: dec.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.aluop = ALU_SUB;
                    FN_AND:          dec.aluop = ALU_AND;
                    FN_OR:           dec.aluop = ALU_OR;
                    FN_XOR:          dec.aluop = ALU_XOR;
                    FN_NOR:          dec.aluop = ALU_NOR;
                    FN_SLT:          dec.aluop = ALU_SLT;
                    FN_SLTU:         dec.aluop = ALU_SLTU;
                    FN_JR:           begin dec.cls = CLS_J; dec.jumpsel = JS_REG; dec.regdest = RD_RT; end
                    default:         begin dec.cls = CLS_NOP; dec.regdest = RD_RT; end
                endcase
            end
            OP_J:     begin dec.cls = CLS_J; dec.jumpsel = JS_TARGET; end
            OP_JAL:   begin
                dec.cls     = CLS_JAL;
                dec.jumpsel = JS_TARGET;
                dec.regdest = RD_R31;
                dec.jal     = 1'b1;
            end
            OP_BEQ:   begin dec.cls = CLS_BR; dec.aluop = ALU_SUB; end
            OP_BNE:   begin dec.cls = CLS_BR; dec.aluop = ALU_SUB; dec.bne = 1'b1; end
            OP_ADDIU: begin dec.cls = CLS_ALU; dec.aluop = ALU_ADD;  dec.alusrc = SRC_SEXT; end
            OP_SLTI:  begin dec.cls = CLS_ALU; dec.aluop = ALU_SLT;  dec.alusrc = SRC_SEXT; end
            OP_SLTIU: begin dec.cls = CLS_ALU; dec.aluop = ALU_SLTU; dec.alusrc = SRC_SEXT; end
            OP_ANDI:  begin dec.cls = CLS_ALU; dec.aluop = ALU_AND;  dec.alusrc = SRC_ZEXT; end
            OP_ORI:   begin dec.cls = CLS_ALU; dec.aluop = ALU_OR;   dec.alusrc = SRC_ZEXT; end
            OP_XORI:  begin dec.cls = CLS_ALU; dec.aluop = ALU_XOR;  dec.alusrc = SRC_ZEXT; end
            OP_LUI:   begin dec.cls = CLS_ALU; dec.lui = 1'b1; end
            OP_LW:    begin
                dec.cls      = CLS_LW;
                dec.aluop    = ALU_ADD;
                dec.alusrc   = SRC_SEXT;
                dec.memtoreg = 1'b1;
            end
            OP_SW:    begin dec.cls = CLS_SW; dec.aluop = ALU_ADD; dec.alusrc = SRC_SEXT; end
            OP_HALT:  dec.cls = CLS_HALT;
            default:  ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS sequencer (optional CU_PERF_COUNTERS_EN perf counters)
module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic CLK,
    input  logic nRST,
`ifdef CU_PERF_COUNTERS_EN
    output word_t cyc_count,
    output word_t instr_count,
`endif
    multicycle_control_unit_if.master cuif
);

    // MEM_TIMEOUT of 0 would give a zero-width counter; keep at least one bit
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    cu_state_t     state;
    word_t         ir;
    logic [CW-1:0] cnt;
    logic          memerr_q;
    logic          tmo_hit;
    decode_t       dec;

    cu_decode u_decode (
        .opcode (ir[31:26]),
        .funct  (ir[5:0]),
        .dec    (dec)
    );

    assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt == TMO);

    // Sequencer: state, instruction register, hit wait counter and sticky timeout flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= FETCH;
            ir       <= '0;
            cnt      <= '0;
            memerr_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (cuif.ihit) begin
                        ir    <= cuif.iload;
                        state <= DECODE;
                        cnt   <= '0;
                    end else if (tmo_hit) begin
                        memerr_q <= 1'b1;
                        state    <= HALT;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECODE: state <= (dec.cls == CLS_HALT) ? HALT : EXEC;
                EXEC: begin
                    case (dec.cls)
                        CLS_LW, CLS_SW:   state <= MEM;
                        CLS_ALU, CLS_JAL: state <= WBACK;
                        default:          state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (cuif.dhit) begin
                        state <= (dec.cls == CLS_LW) ? WBACK : FETCH;
                        cnt   <= '0;
                    end else if (tmo_hit) begin
                        memerr_q <= 1'b1;
                        state    <= HALT;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WBACK:   state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Per-state strobes; everything is forced low while nRST is held
    always_comb begin
        cuif.imemREN  = 1'b0;
        cuif.dREN     = 1'b0;
        cuif.dWEN     = 1'b0;
        cuif.IRWEN    = 1'b0;
        cuif.PCWEN    = 1'b0;
        cuif.RegWEN   = 1'b0;
        cuif.PCSrc    = 1'b0;
        cuif.JumpSel  = JS_PC4;
        cuif.ALUSrc   = SRC_RT;
        cuif.RegDest  = RD_RT;
        cuif.MemtoReg = 1'b0;
        cuif.LUI      = 1'b0;
        cuif.JAL      = 1'b0;
        cuif.aluop    = ALU_SLL;
        if (nRST) begin
            case (state)
                FETCH: begin
                    cuif.imemREN = 1'b1;
                    cuif.IRWEN   = cuif.ihit;
                    cuif.PCWEN   = cuif.ihit;
                end
                EXEC: begin
                    cuif.aluop  = dec.aluop;
                    cuif.ALUSrc = dec.alusrc;
                    case (dec.cls)
                        CLS_BR: begin
                            cuif.PCSrc = cuif.zero ^ dec.bne;
                            cuif.PCWEN = cuif.zero ^ dec.bne;
                        end
                        CLS_J, CLS_JAL: begin
                            cuif.PCWEN   = 1'b1;
                            cuif.JumpSel = dec.jumpsel;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    cuif.aluop  = dec.aluop;
                    cuif.ALUSrc = dec.alusrc;
                    cuif.dREN   = (dec.cls == CLS_LW);
                    cuif.dWEN   = (dec.cls == CLS_SW);
                end
                WBACK: begin
                    cuif.aluop    = dec.aluop;
                    cuif.ALUSrc   = dec.alusrc;
                    cuif.RegWEN   = 1'b1;
                    cuif.RegDest  = dec.regdest;
                    cuif.MemtoReg = dec.memtoreg;
                    cuif.LUI      = dec.lui;
                    cuif.JAL      = dec.jal;
                end
                default: ;
            endcase
        end
    end

    assign cuif.rs     = ir[25:21];
    assign cuif.rt     = ir[20:16];
    assign cuif.rd     = ir[15:11];
    assign cuif.imm    = ir[15:0];
    assign cuif.shamt  = {27'd0, ir[10:6]};
    assign cuif.halt   = nRST && (state == HALT);
    assign cuif.memerr = memerr_q;

`ifdef CU_PERF_COUNTERS_EN
    logic to_fetch;

    assign to_fetch = ((state == EXEC) && (dec.cls inside {CLS_NOP, CLS_BR, CLS_J}))
                   || ((state == MEM) && cuif.dhit && (dec.cls == CLS_SW))
                   || (state == WBACK);

    // Cycle and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cyc_count   <= '0;
            instr_count <= '0;
        end else begin
            if (state != HALT) cyc_count <= cyc_count + 32'd1;
            if (to_fetch) instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
    import cpu_types_pkg::*;

    localparam word_t I_ADDU = 32'h0022_1821;  // addu r3,r1,r2
    localparam word_t I_LW   = 32'h8C85_0008;  // lw   r5,8(r4)
    localparam word_t I_SW   = 32'hAC85_000C;  // sw   r5,12(r4)
    localparam word_t I_BEQ  = 32'h1022_0004;  // beq  r1,r2,4
    localparam word_t I_BNE  = 32'h1422_0004;  // bne  r1,r2,4
    localparam word_t I_J    = 32'h0800_0010;  // j    0x40
    localparam word_t I_HALT = 32'hFC00_0000;
    localparam word_t I_UNK  = 32'hF800_0000;  // opcode 0x3E, undefined

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n_dren;

    multicycle_control_unit_if bus ();
`ifdef CU_PERF_COUNTERS_EN
    word_t cyc_count;
    word_t instr_count;
`endif

    multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
`ifdef CU_PERF_COUNTERS_EN
        .cyc_count   (cyc_count),
        .instr_count (instr_count),
`endif
        .cuif        (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST      = 1'b0;
        bus.ihit  = 1'b0;
        bus.dhit  = 1'b0;
        bus.zero  = 1'b0;
        bus.iload = '0;
        #1;
        tick();
        nRST = 1'b1;
        #1;
    endtask

    // From a FETCH cycle: hit immediately, pass DECODE, return sitting in EXEC
    task automatic fetch_to_exec(input word_t ins);
        bus.iload = ins;
        bus.ihit  = 1'b1;
        #1;
        check("fetch_strobes", {bus.imemREN, bus.IRWEN, bus.PCWEN}, 3'b111);
        tick();
        bus.ihit = 1'b0;
        #1;
        check("decode_quiet", {bus.imemREN, bus.IRWEN, bus.PCWEN, bus.RegWEN}, 4'b0000);
        tick();
    endtask

    task automatic run_branch(input string tag, input word_t ins, input logic z, input logic taken);
        fetch_to_exec(ins);
        bus.zero = z;
        #1;
        check(tag, {bus.PCWEN, bus.PCSrc}, {taken, taken});
        tick();
        bus.zero = 1'b0;
        #1;
        check("branch_back_fetch", bus.imemREN, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.iload = '0;
        bus.ihit  = 1'b0;
        bus.dhit  = 1'b0;
        bus.zero  = 1'b0;
        nRST      = 1'b0;
        #2;
        check("rst_strobes", {bus.imemREN, bus.IRWEN, bus.PCWEN, bus.RegWEN, bus.dREN, bus.dWEN}, 0);
        check("rst_flags", {bus.halt, bus.memerr}, 0);
        check("rst_aluop", bus.aluop, ALU_SLL);
        check("rst_selects", {bus.JumpSel, bus.ALUSrc, bus.RegDest}, 0);
        check("rst_ir_fields", {bus.rs, bus.rt, bus.rd}, 0);
        tick();
        nRST = 1'b1;
        #1;

        // ADDU r3,r1,r2: WBACK in cycle 4, FETCH in cycle 5
        check("first_fetch", bus.imemREN, 1);
        fetch_to_exec(I_ADDU);
        check("addu_aluop", bus.aluop, ALU_ADD);
        check("addu_fields", {bus.rs, bus.rt, bus.rd}, {5'd1, 5'd2, 5'd3});
        check("addu_exec_noreg", bus.RegWEN, 0);
        tick();
        check("addu_wback", {bus.RegWEN, bus.RegDest, bus.MemtoReg}, {1'b1, RD_RD, 1'b0});
        tick();
        check("addu_refetch", {bus.imemREN, bus.RegWEN}, 2'b10);

        // LW with three data waits: dREN for 4 cycles, 8 cycles total
        fetch_to_exec(I_LW);
        check("lw_exec", {bus.aluop, bus.ALUSrc}, {ALU_ADD, SRC_SEXT});
        tick();
        n_dren = 0;
        for (int i = 0; i < 4; i++) begin
            bus.dhit = (i == 3);
            #1;
            if (bus.dREN) n_dren++;
            tick();
        end
        bus.dhit = 1'b0;
        #1;
        check("lw_dren_cycles", n_dren, 4);
        check("lw_wback", {bus.RegWEN, bus.MemtoReg, bus.dREN, bus.RegDest}, {1'b1, 1'b1, 1'b0, RD_RT});
        check("lw_no_memerr", bus.memerr, 0);
        tick();
        check("lw_refetch", bus.imemREN, 1);

        run_branch("beq_taken", I_BEQ, 1'b1, 1'b1);
        run_branch("beq_not_taken", I_BEQ, 1'b0, 1'b0);
        run_branch("bne_zero_set", I_BNE, 1'b1, 1'b0);
        run_branch("bne_zero_clear", I_BNE, 1'b0, 1'b1);

        // SW with hit in the entry cycle of MEM
        fetch_to_exec(I_SW);
        tick();
        bus.dhit = 1'b1;
        #1;
        check("sw_entry_hit", {bus.dWEN, bus.dREN}, 2'b10);
        tick();
        bus.dhit = 1'b0;
        #1;
        check("sw_refetch", {bus.imemREN, bus.dWEN, bus.RegWEN}, 3'b100);

        // Reset while a store is pending
        fetch_to_exec(I_SW);
        tick();
        check("sw_pending", bus.dWEN, 1);
        nRST = 1'b0;
        #1;
        check("sw_reset_drop", {bus.dWEN, bus.imemREN}, 2'b00);
        tick();
        nRST = 1'b1;
        #1;
        check("sw_reset_fetch", bus.imemREN, 1);

        // Undefined opcode behaves as a NOP
        fetch_to_exec(I_UNK);
        check("unk_exec_quiet", {bus.PCWEN, bus.RegWEN, bus.dREN, bus.dWEN}, 4'b0000);
        tick();
        check("unk_refetch", bus.imemREN, 1);

        // ihit arriving when the counter equals MEM_TIMEOUT wins
        for (int i = 0; i < 4; i++) tick();
        bus.iload = I_ADDU;
        bus.ihit  = 1'b1;
        #1;
        check("late_hit_accept", bus.IRWEN, 1);
        tick();
        bus.ihit = 1'b0;
        #1;
        check("late_hit_no_err", {bus.memerr, bus.halt, bus.imemREN}, 3'b000);

        // Fetch timeout with MEM_TIMEOUT=4
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("tmo_waiting", {bus.imemREN, bus.halt, bus.memerr}, 3'b100);
            tick();
        end
        check("tmo_halted", {bus.memerr, bus.halt, bus.imemREN}, 3'b110);
        tick();
        check("tmo_sticky", {bus.memerr, bus.halt, bus.imemREN}, 3'b110);

        // HALT opcode and reset recovery
        do_reset();
        check("halt_rst_clear", {bus.halt, bus.memerr}, 0);
        bus.iload = I_HALT;
        bus.ihit  = 1'b1;
        #1;
        tick();
        bus.ihit = 1'b0;
        #1;
        check("halt_decode", bus.halt, 0);
        tick();
        check("halt_enter", {bus.halt, bus.imemREN, bus.PCWEN, bus.RegWEN}, 4'b1000);
        tick();
        tick();
        tick();
        check("halt_persist", {bus.halt, bus.memerr}, 2'b10);
        nRST = 1'b0;
        #1;
        check("halt_in_reset", bus.halt, 0);
        tick();
        nRST = 1'b1;
        #1;
        check("halt_recover", {bus.halt, bus.imemREN}, 2'b01);

`ifdef CU_PERF_COUNTERS_EN
        // ADDU(4) + SW(4) + J(3) + HALT(2) = 13 cycles, 3 retired
        do_reset();
        fetch_to_exec(I_ADDU);
        tick();
        tick();
        fetch_to_exec(I_SW);
        tick();
        bus.dhit = 1'b1;
        tick();
        bus.dhit = 1'b0;
        fetch_to_exec(I_J);
        check("j_exec", {bus.PCWEN, bus.JumpSel}, {1'b1, JS_TARGET});
        tick();
        bus.iload = I_HALT;
        bus.ihit  = 1'b1;
        tick();
        bus.ihit = 1'b0;
        tick();
        tick();
        tick();
        check("perf_halt", bus.halt, 1);
        check("perf_cyc", cyc_count, 13);
        check("perf_instr", instr_count, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
